// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus bundle: control-path redirect, if/id consumer handshake,
// and the instruction-memory request/acknowledge channel.
interface instruction_fetch_unit_if #(
  parameter int ISA_WIDTH = 32
);
  // Redirect from the control path
  logic                 pc_offset;
  logic [ISA_WIDTH-1:0] pc_target;

  // Consumer (if/id) side
  logic                 if_hold;
  logic                 if_valid;
  logic [ISA_WIDTH-1:0] if_pc;
  logic [ISA_WIDTH-1:0] if_instruction;

  // Instruction memory side
  logic                 imem_req;
  logic [ISA_WIDTH-1:0] imem_addr;
  logic                 imem_ack;
  logic [ISA_WIDTH-1:0] imem_rdata;

  // The fetch unit drives requests and the if/id view
  modport master (
    input  pc_offset, pc_target, if_hold, imem_ack, imem_rdata,
    output imem_req, imem_addr, if_valid, if_pc, if_instruction
  );

  // Memory, control path and consumer side
  modport slave (
    output pc_offset, pc_target, if_hold, imem_ack, imem_rdata,
    input  imem_req, imem_addr, if_valid, if_pc, if_instruction
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word fetch at a time to
// instruction memory, and buffers returned (pc, instruction) pairs in a small
// shift-register FIFO whose head drives the if/id outputs directly. A redirect
// flushes the FIFO and abandons (or drains) the in-flight fetch.
module instruction_fetch_unit #(
  parameter int                   ISA_WIDTH  = 32,
  parameter logic [ISA_WIDTH-1:0] RESET_PC   = '0,
  parameter int                   FIFO_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  instruction_fetch_unit_if.master   bus
);

  localparam int                   CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]        DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]        DEPTH_M1_C = CW'(FIFO_DEPTH - 1);
  localparam logic [ISA_WIDTH-1:0] WORD_STEP  = ISA_WIDTH'(4);
  localparam logic [ISA_WIDTH-1:0] ALIGN_MASK = ~ISA_WIDTH'(3);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  // Fetch control registers
  state_t               r_state;
  state_t               w_state_nxt;
  logic [ISA_WIDTH-1:0] r_fetch_pc;
  logic [ISA_WIDTH-1:0] w_fetch_pc_nxt;
  logic [ISA_WIDTH-1:0] r_addr;
  logic [ISA_WIDTH-1:0] w_addr_nxt;
  logic                 r_req;
  logic                 w_req_nxt;

  // FIFO storage; entry 0 is always the head, entries are packed from 0 up
  logic [ISA_WIDTH-1:0] r_fifo_pc  [FIFO_DEPTH];
  logic [ISA_WIDTH-1:0] r_fifo_ins [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_fifo_vld;
  logic [ISA_WIDTH-1:0] w_fifo_pc  [FIFO_DEPTH];
  logic [ISA_WIDTH-1:0] w_fifo_ins [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] w_fifo_vld;
  logic [CW-1:0]        r_count;
  logic [CW-1:0]        w_count_nxt;

  logic                 w_pop;
  logic                 w_push;
  logic                 w_flush;
  logic [ISA_WIDTH-1:0] w_target;
  logic [ISA_WIDTH-1:0] w_addr_inc;
  logic [CW-1:0]        w_wr_idx;

  // Redirect targets are forced word-aligned; PC increment wraps naturally.
  assign w_target   = bus.pc_target & ALIGN_MASK;
  assign w_addr_inc = r_addr + WORD_STEP;
  assign w_flush    = bus.pc_offset;
  assign w_pop      = r_fifo_vld[0] & ~bus.if_hold;
  assign w_push     = (r_state == S_WAIT) & bus.imem_ack & ~bus.pc_offset;
  // A simultaneous pop shifts the queue down before the new entry lands.
  assign w_wr_idx   = r_count - {{(CW-1){1'b0}}, w_pop};

  // Outputs come straight from registers.
  assign bus.imem_req       = r_req;
  assign bus.imem_addr      = r_addr;
  assign bus.if_valid       = r_fifo_vld[0];
  assign bus.if_pc          = r_fifo_pc[0];
  assign bus.if_instruction = r_fifo_ins[0];

  // Fetch FSM and request registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_addr     <= '0;
      r_req      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_addr     <= w_addr_nxt;
      r_req      <= w_req_nxt;
    end
  end

  // Next-state logic: one outstanding request, with a FIFO slot always
  // reserved for it, so a fetch is only launched while the FIFO has room.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_addr_nxt     = r_addr;
    w_req_nxt      = r_req;
    case (r_state)
      S_IDLE: begin
        if (bus.pc_offset) begin
          w_fetch_pc_nxt = w_target;
        end else if (r_count < DEPTH_C) begin
          w_req_nxt   = 1'b1;
          w_addr_nxt  = r_fetch_pc;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.imem_ack && !bus.pc_offset) begin
          w_fetch_pc_nxt = w_addr_inc;
          // Keep streaming only if a slot remains after this push/pop.
          if (w_pop || (r_count < DEPTH_M1_C)) begin
            w_addr_nxt = w_addr_inc;
          end else begin
            w_req_nxt   = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end else if (bus.pc_offset && !bus.imem_ack) begin
          // The request must still complete; its data will be dropped.
          w_fetch_pc_nxt = w_target;
          w_state_nxt    = S_DISCARD;
        end else if (bus.pc_offset && bus.imem_ack) begin
          w_fetch_pc_nxt = w_target;
          w_req_nxt      = 1'b0;
          w_state_nxt    = S_IDLE;
        end
      end
      S_DISCARD: begin
        if (bus.pc_offset) begin
          w_fetch_pc_nxt = w_target;
        end
        if (bus.imem_ack) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FIFO next contents: shift on pop, insert on push, flush wins over both.
  always_comb begin
    w_fifo_pc   = r_fifo_pc;
    w_fifo_ins  = r_fifo_ins;
    w_fifo_vld  = r_fifo_vld;
    w_count_nxt = r_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};
    if (w_pop) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
        w_fifo_pc[i]  = r_fifo_pc[i+1];
        w_fifo_ins[i] = r_fifo_ins[i+1];
        w_fifo_vld[i] = r_fifo_vld[i+1];
      end
      w_fifo_pc[FIFO_DEPTH-1]  = '0;
      w_fifo_ins[FIFO_DEPTH-1] = '0;
      w_fifo_vld[FIFO_DEPTH-1] = 1'b0;
    end
    if (w_push) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (CW'(i) == w_wr_idx) begin
          w_fifo_pc[i]  = r_addr;
          w_fifo_ins[i] = bus.imem_rdata;
          w_fifo_vld[i] = 1'b1;
        end
      end
    end
    if (w_flush) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        w_fifo_pc[i]  = '0;
        w_fifo_ins[i] = '0;
      end
      w_fifo_vld  = '0;
      w_count_nxt = '0;
    end
  end

  // FIFO registers; empty slots hold zero so the head reads 0 when empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_pc[i]  <= '0;
        r_fifo_ins[i] <= '0;
      end
      r_fifo_vld <= '0;
      r_count    <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_pc[i]  <= w_fifo_pc[i];
        r_fifo_ins[i] <= w_fifo_ins[i];
      end
      r_fifo_vld <= w_fifo_vld;
      r_count    <= w_count_nxt;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: directed scenarios plus a random
// phase, with a variable-latency memory model and a scoreboard of the
// expected in-order (pc, instruction) stream.
module tb_instruction_fetch_unit;
  localparam int          W      = 32;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instruction_fetch_unit_if #(.ISA_WIDTH(W)) bus();

  instruction_fetch_unit #(
    .ISA_WIDTH (W),
    .RESET_PC  (RST_PC),
    .FIFO_DEPTH(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] next_pc;
  int          n_vec = 0;
  int          n_err = 0;
  int          lat_mode = 0;   // -1: random 0..3 wait cycles per request
  bit          force_ack = 1'b0;
  bit          prev_rst = 1'b0;
  bit          prev_flush = 1'b0;

  // Memory contents as a pure function of the word address
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected stream: consecutive words from the latest restart point
  task automatic topup();
    exp_t e;
    while (sb_q.size() < 16) begin
      e.pc  = next_pc;
      e.ins = memf(next_pc);
      sb_q.push_back(e);
      next_pc = next_pc + 32'd4;
    end
  endtask

  task automatic restart(input logic [31:0] pc);
    sb_q.delete();
    next_pc = pc;
    topup();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    topup();
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    bus.pc_offset = 1'b0;
    restart(RST_PC);
    repeat (cycles) tick();
    rst_n = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] t);
    bus.pc_offset = 1'b1;
    bus.pc_target = t;
    restart(t & 32'hFFFF_FFFC);
    tick();
    bus.pc_offset = 1'b0;
  endtask

  task automatic wait_req(input string nm, input logic [31:0] addr);
    int n = 0;
    while (!(bus.imem_req && bus.imem_addr == addr) && n < 50) begin
      tick();
      n++;
    end
    chk(nm, {31'd0, bus.imem_req && bus.imem_addr == addr}, 32'd1);
  endtask

  task automatic wait_valid(input string nm, input int exp_lat);
    int lat = 1;
    while (!bus.if_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk(nm, 32'(lat), 32'(exp_lat));
  endtask

  // Memory model: ack after a per-request number of wait cycles
  initial begin : memory_model
    bit          busy = 1'b0;
    int          wcnt = 0;
    logic [31:0] cur_addr = '0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (force_ack) begin
        force_ack      = 1'b0;
        busy           = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = $urandom;
      end else if (!rst_n || !bus.imem_req) begin
        busy           = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
      end else begin
        if (!busy || bus.imem_ack) begin
          busy     = 1'b1;
          cur_addr = bus.imem_addr;
          wcnt     = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
          chk("addr_align", {30'd0, bus.imem_addr[1:0]}, 32'd0);
        end else begin
          chk("addr_stable", bus.imem_addr, cur_addr);
        end
        bus.imem_ack = (wcnt == 0);
        if (wcnt != 0) wcnt--;
        bus.imem_rdata = bus.imem_ack ? memf(bus.imem_addr) : $urandom;
      end
    end
  end

  // Monitor: compare every consumed head against the scoreboard
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (prev_rst) begin
        chk("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_imem_addr", bus.imem_addr, 32'd0);
        chk("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("rst_if_pc", bus.if_pc, 32'd0);
        chk("rst_if_instruction", bus.if_instruction, 32'd0);
      end else if (prev_flush) begin
        chk("flush_if_valid", {31'd0, bus.if_valid}, 32'd0);
      end
      if (rst_n && !bus.if_valid) begin
        chk("empty_if_pc", bus.if_pc, 32'd0);
        chk("empty_if_instruction", bus.if_instruction, 32'd0);
      end
      if (rst_n && !bus.pc_offset && bus.if_valid && !bus.if_hold) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL scoreboard_underflow: got pc %08h, expected none", bus.if_pc);
        end else begin
          mon_e = sb_q.pop_front();
          chk("if_pc", bus.if_pc, mon_e.pc);
          chk("if_instruction", bus.if_instruction, mon_e.ins);
        end
      end
      prev_rst   = !rst_n;
      prev_flush = bus.pc_offset;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [31:0] t;
    int          r;
    bus.pc_offset = 1'b0;
    bus.pc_target = '0;
    bus.if_hold   = 1'b0;
    #1;

    // Reset, then zero-wait streaming
    lat_mode = 0;
    do_reset(3);
    wait_valid("reset_first_valid_latency", 3);
    repeat (8) tick();
    chk("stream_imem_req", {31'd0, bus.imem_req}, 32'd1);

    // Backpressure fills the FIFO and stops fetching
    bus.if_hold = 1'b1;
    repeat (6) tick();
    chk("hold_imem_req", {31'd0, bus.imem_req}, 32'd0);
    chk("hold_if_valid", {31'd0, bus.if_valid}, 32'd1);
    chk("hold_head_pc", bus.if_pc, sb_q[0].pc);
    bus.if_hold = 1'b0;
    repeat (8) tick();

    // Redirect while a slow fetch is outstanding
    lat_mode = 3;
    redirect(32'h20);
    wait_req("req_0x20", 32'h20);
    tick();
    redirect(32'h100);
    chk("discard_imem_req", {31'd0, bus.imem_req}, 32'd1);
    chk("discard_imem_addr", bus.imem_addr, 32'h20);
    wait_req("req_0x100", 32'h100);
    repeat (20) tick();

    // Redirect coinciding with an ack, one entry buffered
    lat_mode = 0;
    redirect(32'h0);
    wait_req("req_0x8", 32'h8);
    chk("one_entry_valid", {31'd0, bus.if_valid}, 32'd1);
    redirect(32'h40);
    wait_valid("redirect_first_valid_latency", 3);
    repeat (10) tick();

    // Reset in the middle of a request; a late ack must be ignored
    lat_mode = 3;
    redirect(32'h200);
    wait_req("req_0x200", 32'h200);
    tick();
    do_reset(1);
    force_ack = 1'b1;
    wait_req("req_after_reset", RST_PC);
    lat_mode = 0;
    repeat (15) tick();

    // Address wrap and target alignment
    redirect(32'hFFFF_FFFC);
    repeat (10) tick();
    redirect(32'h103);
    wait_req("req_aligned_0x100", 32'h100);
    repeat (10) tick();

    // Random phase
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) lat_mode = int'($urandom_range(0, 4)) - 1;
      bus.if_hold = ($urandom_range(0, 3) == 0);
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        case ($urandom_range(0, 3))
          0:       t = 32'hFFFF_FFFC;
          1:       t = $urandom;
          2:       t = $urandom & 32'h0000_0FFC;
          default: t = 32'h103;
        endcase
        redirect(t);
      end else if (r == 3 && $urandom_range(0, 9) == 0) begin
        do_reset(int'($urandom_range(1, 2)));
      end else begin
        tick();
      end
    end

    bus.if_hold = 1'b0;
    repeat (20) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
